// File: rtl/packet_receiver.sv
// packet_receiver: sink for a sop/eop/wren word stream. Frames words into
// packets, buffers them in a FIFO with registered rdy flow control, and
// re-emits them on a valid/ready interface with abort tagging and
// framing-error reporting.
// Optional build macro PKT_RX_STATS_EN: when defined, pkt_count/err_count are
// saturating statistics counters; when undefined both ports read 0.
module packet_receiver #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 64
) (
  input  logic              clk_hifreq,
  input  logic              rst,
  input  logic              en,
  input  logic              sop,
  input  logic              eop,
  input  logic              wren,
  input  logic [DATA_W-1:0] datain,
  output logic              rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              ovf_err,
  output logic [15:0]       pkt_count,
  output logic [15:0]       err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int EW = DATA_W + 3;   // {abort, sop, eop, data}

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t          state_reg, state_next;
  logic [LW-1:0]   len_reg, len_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic [EW-1:0]   mem_reg [DEPTH];
  logic [EW-1:0]   wr_entry, head;
  logic            accept, rd_fire, full, ovf_hit;
  logic            wr_fire, fsm_err, pkt_done;
  logic            rdy_reg, frame_err_reg, ovf_err_reg;

  assign accept  = wren && en;
  assign full    = (count_reg == CW'(DEPTH));
  assign rd_fire = out_valid && out_ready;

  // Framing decode: decides what (if anything) the accepted word writes and
  // where the FSM goes; an overflow drop freezes the FSM and suppresses the write.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    wr_fire    = 1'b0;
    wr_entry   = {1'b0, sop, eop, datain};
    fsm_err    = 1'b0;
    pkt_done   = 1'b0;
    ovf_hit    = accept && full && !rd_fire;
    if (accept) begin
      case (state_reg)
        IDLE, DROP: begin
          if (sop) begin
            wr_fire  = 1'b1;
            wr_entry = {1'b0, 1'b1, eop, datain};
            if (eop) begin
              pkt_done   = 1'b1;
              state_next = IDLE;
            end else begin
              len_next   = LW'(1);
              state_next = RECV;
            end
          end else if (state_reg == IDLE) begin
            fsm_err = 1'b1;            // stray word outside a packet
          end else if (eop) begin
            state_next = IDLE;         // tail of a truncated packet ends
          end
        end
        RECV: begin
          if (sop) begin
            // New packet cuts the current one short: tag it as an abort.
            wr_fire  = 1'b1;
            wr_entry = {1'b1, 1'b1, eop, datain};
            fsm_err  = 1'b1;
            len_next = LW'(1);
            if (eop) begin
              pkt_done   = 1'b1;
              state_next = IDLE;
            end
          end else if (eop) begin
            wr_fire    = 1'b1;
            wr_entry   = {1'b0, 1'b0, 1'b1, datain};
            pkt_done   = 1'b1;
            state_next = IDLE;
          end else if (len_reg == LW'(MAX_LEN - 1)) begin
            // Packet too long: close it here and discard the remainder.
            wr_fire    = 1'b1;
            wr_entry   = {1'b0, 1'b0, 1'b1, datain};
            fsm_err    = 1'b1;
            state_next = DROP;
          end else begin
            wr_fire  = 1'b1;
            wr_entry = {1'b0, 1'b0, 1'b0, datain};
            len_next = len_reg + LW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
    if (ovf_hit) begin
      state_next = state_reg;
      len_next   = len_reg;
      wr_fire    = 1'b0;
      fsm_err    = 1'b0;
      pkt_done   = 1'b0;
    end
  end

  assign count_next = count_reg + CW'(wr_fire) - CW'(rd_fire);

  // FSM, FIFO pointers/occupancy and registered status outputs.
  always_ff @(posedge clk_hifreq or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rdy_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
      ovf_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      count_reg     <= count_next;
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      // Two free entries cover the sender's one-cycle reaction to rdy.
      rdy_reg       <= en && (count_next <= CW'(DEPTH - 2));
      frame_err_reg <= fsm_err || ovf_hit;
      if (ovf_hit) ovf_err_reg <= 1'b1;
    end
  end

  // FIFO storage: one write-enabled register per entry, no reset needed.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk_hifreq) begin
        if (wr_fire && (wr_ptr_reg == AW'(gi))) mem_reg[gi] <= wr_entry;
      end
    end
  endgenerate

  // Head is shown combinationally and masked to 0 while the FIFO is empty.
  assign head      = mem_reg[rd_ptr_reg];
  assign out_valid = (count_reg != '0);
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_eop   = out_valid && head[DATA_W];
  assign out_sop   = out_valid && head[DATA_W+1];
  assign out_abort = out_valid && head[DATA_W+2];
  assign rdy       = rdy_reg;
  assign frame_err = frame_err_reg;
  assign ovf_err   = ovf_err_reg;

`ifdef PKT_RX_STATS_EN
  logic [15:0] pkt_count_reg, err_count_reg;

  // Saturating statistics: completed packets and error pulses.
  always_ff @(posedge clk_hifreq or negedge rst) begin
    if (!rst) begin
      pkt_count_reg <= '0;
      err_count_reg <= '0;
    end else begin
      if (pkt_done && (pkt_count_reg != 16'hFFFF))
        pkt_count_reg <= pkt_count_reg + 16'd1;
      if ((fsm_err || ovf_hit) && (err_count_reg != 16'hFFFF))
        err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign pkt_count = pkt_count_reg;
  assign err_count = err_count_reg;
`else
  assign pkt_count = 16'd0;
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: directed stimulus with a scoreboard queue; a monitor
// process pops expected words whenever the DUT transfers an output word.
module tb_packet_receiver;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int MAX_LEN = 64;
`ifdef PKT_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk_hifreq = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0, sop = 1'b0, eop = 1'b0, wren = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] datain = '0;
  logic              rdy, out_sop, out_eop, out_abort, out_valid;
  logic              frame_err, ovf_err;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       pkt_count, err_count;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  logic [DATA_W+2:0] sb_q[$];

  packet_receiver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk_hifreq(clk_hifreq), .rst(rst), .en(en), .sop(sop), .eop(eop),
    .wren(wren), .datain(datain), .rdy(rdy), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_abort(out_abort),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err),
    .ovf_err(ovf_err), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk_hifreq = ~clk_hifreq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic a, input logic s, input logic e, input logic [DATA_W-1:0] d);
    sb_q.push_back({a, s, e, d});
  endtask

  task automatic send(input logic s, input logic e, input logic [DATA_W-1:0] d);
    sop = s; eop = e; datain = d; wren = 1'b1;
    @(posedge clk_hifreq); #1;
    wren = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk_hifreq); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b0; cycles(1);
    rst = 1'b1; cycles(2);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) cycles(1);
    cycles(2);
    check(name, sb_q.size(), 0);
  endtask

  // Monitor: every transferred word must match the head of the scoreboard.
  initial begin
    logic [DATA_W+2:0] req;
    forever begin
      @(negedge clk_hifreq);
      if (!rst) begin
        sb_q.delete();
      end else begin
        if (frame_err) fe_cnt++;
        if (out_valid && out_ready) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word: got %0h required none", {out_abort, out_sop, out_eop, out_data});
          end else begin
            req = sb_q.pop_front();
            $display("xfer abort=%0b sop=%0b eop=%0b data=%0h", out_abort, out_sop, out_eop, out_data);
            if ({out_abort, out_sop, out_eop, out_data} !== req) begin
              bad++;
              $display("FAIL out_word: got %0h required %0h", {out_abort, out_sop, out_eop, out_data}, req);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int fe0;
    // Reset state
    en = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_rdy", rdy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_err", err_count, 0);
    @(posedge clk_hifreq); #1;
    rst = 1'b1;
    cycles(2);
    check("rdy_up", rdy, 1);
    check("idle_valid", out_valid, 0);

    // 4-word packet streamed straight through
    out_ready = 1'b1;
    expect_word(0, 1, 0, 32'hA0); send(1, 0, 32'hA0);
    check("wr_to_valid", out_valid, 1);
    expect_word(0, 0, 0, 32'hA1); send(0, 0, 32'hA1);
    expect_word(0, 0, 0, 32'hA2); send(0, 0, 32'hA2);
    expect_word(0, 0, 1, 32'hA3); send(0, 1, 32'hA3);
    drain("drain_a");
    check("pkt_a", pkt_count, STATS ? 1 : 0);

    // Fill while honouring rdy, then overflow by ignoring it
    do_reset();
    out_ready = 1'b0;
    sent = 0;
    for (int i = 0; i < 40 && rdy; i++) begin
      expect_word(0, 1, 1, 32'h100 + i);
      send(1, 1, 32'h100 + i);
      sent++;
    end
    check("fill_sent", sent, DEPTH - 1);
    check("fill_ovf", ovf_err, 0);
    expect_word(0, 1, 1, 32'h1FF); send(1, 1, 32'h1FF);
    check("full_ovf", ovf_err, 0);
    check("full_valid", out_valid, 1);
    fe0 = fe_cnt;
    send(1, 1, 32'hDEAD);
    check("ovf_set", ovf_err, 1);
    cycles(1);
    check("ovf_pulse", fe_cnt - fe0, 1);
    check("ovf_pulse_end", frame_err, 0);
    out_ready = 1'b1;
    drain("drain_fill");
    check("ovf_sticky", ovf_err, 1);
    check("pkt_fill", pkt_count, STATS ? DEPTH : 0);
    check("err_fill", err_count, STATS ? 1 : 0);

    // sop inside a packet: abort tag on the new sop word
    do_reset();
    fe0 = fe_cnt;
    expect_word(0, 1, 0, 32'hB0); send(1, 0, 32'hB0);
    expect_word(0, 0, 0, 32'hB1); send(0, 0, 32'hB1);
    expect_word(1, 1, 0, 32'hB2); send(1, 0, 32'hB2);
    expect_word(0, 0, 1, 32'hB3); send(0, 1, 32'hB3);
    drain("drain_abort");
    check("abort_pulse", fe_cnt - fe0, 1);
    check("abort_err", err_count, STATS ? 1 : 0);
    check("abort_pkt", pkt_count, STATS ? 1 : 0);

    // Over-length packet: forced eop on word MAX_LEN, remainder dropped
    do_reset();
    fe0 = fe_cnt;
    for (int i = 1; i <= 70; i++) begin
      if (i < MAX_LEN)       expect_word(0, (i == 1), 0, 32'h7000 + i);
      else if (i == MAX_LEN) expect_word(0, 0, 1, 32'h7000 + i);
      send((i == 1), (i == 70), 32'h7000 + i);
    end
    expect_word(0, 1, 0, 32'hC0); send(1, 0, 32'hC0);
    expect_word(0, 0, 1, 32'hC1); send(0, 1, 32'hC1);
    drain("drain_long");
    check("long_pulse", fe_cnt - fe0, 1);
    check("long_err", err_count, STATS ? 1 : 0);
    check("long_pkt", pkt_count, STATS ? 1 : 0);

    // Asynchronous reset in the middle of a packet
    do_reset();
    out_ready = 1'b0;
    expect_word(0, 1, 0, 32'hD0); send(1, 0, 32'hD0);
    expect_word(0, 0, 0, 32'hD1); send(0, 0, 32'hD1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_sop", out_sop, 0);
    check("arst_rdy", rdy, 0);
    @(posedge clk_hifreq); #1;
    rst = 1'b1;
    cycles(2);
    out_ready = 1'b1;
    expect_word(0, 1, 0, 32'hE0); send(1, 0, 32'hE0);
    expect_word(0, 0, 1, 32'hE1); send(0, 1, 32'hE1);
    drain("drain_post_rst");
    check("post_rst_pkt", pkt_count, STATS ? 1 : 0);
    check("post_rst_err", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
